// File: rtl/sipo_frame_rx_pkg.sv
// Shared types and frame-geometry helpers for the serial frame receiver.
package sipo_frame_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int DATA_W_DEF    = 8;
  localparam int PARITY_EN_DEF = 1;

  function automatic int frame_len(input int dw, input int pe);
    return 2 + dw + pe;
  endfunction

  localparam int FRAME_LEN = frame_len(DATA_W_DEF, PARITY_EN_DEF);

  function automatic int cnt_w(input int dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/sipo_frame_rx_hold_reg.sv
// One-entry valid/ready holding register with sticky overrun.
module rx_hold_reg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] payload,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         overrun
);

  // A load may land on the same edge the held word drains.
  always_ff @(posedge clk) begin
    if (!clr) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (load && (!valid || ready)) begin
      data  <= payload;
      valid <= 1'b1;
    end else begin
      if (load)
        overrun <= 1'b1;
      if (valid && ready)
        valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start, LSB-first data, optional parity, stop.
module sipo_frame_rx
  import sipo_frame_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ser_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  rx_state_t         state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              perr;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!ser_in) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          shreg[cnt] <= ser_in;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST)
            state <= (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          perr  <= ((^shreg) ^ ser_in) != 1'(PARITY_ODD);
          state <= STOP;
        end
        STOP: begin
          state <= ser_in ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (ser_in)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic                commit;
  logic [DATA_W+1:0]   payload;
  logic [DATA_W+1:0]   held;

  assign commit  = (state == STOP);
  assign payload = {~ser_in, perr, shreg};
  assign busy    = (state != IDLE);

  rx_hold_reg #(
    .W(DATA_W + 2)
  ) u_hold (
    .clk    (clk),
    .clr    (clr),
    .load   (commit),
    .payload(payload),
    .ready  (rx_ready),
    .data   (held),
    .valid  (rx_valid),
    .overrun(overrun)
  );

  assign rx_data = held[DATA_W-1:0];
  assign rx_perr = held[DATA_W];
  assign rx_ferr = held[DATA_W+1];

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx (parity and no-parity builds).
module tb_sipo_frame_rx;
  import sipo_frame_rx_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic       ser0, ser1;
  logic       ready;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       perr0, perr1;
  logic       ferr0, ferr1;
  logic       ovr0, ovr1;
  logic       busy0, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sipo_frame_rx #(
    .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut0 (
    .clk(clk), .clr(clr), .ser_in(ser0),
    .rx_data(data0), .rx_valid(valid0), .rx_ready(ready),
    .rx_perr(perr0), .rx_ferr(ferr0),
    .overrun(ovr0), .busy(busy0)
  );

  sipo_frame_rx #(
    .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut1 (
    .clk(clk), .clr(clr), .ser_in(ser1),
    .rx_data(data1), .rx_valid(valid1), .rx_ready(ready),
    .rx_perr(perr1), .rx_ferr(ferr1),
    .overrun(ovr1), .busy(busy1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [7:0] d,
                                     input logic p,
                                     input logic s,
                                     input bit pe);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (pe) begin
      f[9]  = p;
      f[10] = s;
    end else begin
      f[9] = s;
    end
    return f;
  endfunction

  task automatic send(input logic [15:0] bits,
                      input int lo, input int hi,
                      input int which);
    for (int i = lo; i < hi; i++) begin
      if (which == 0) ser0 = bits[i];
      else ser1 = bits[i];
      tick();
    end
    ser0 = 1'b1;
    ser1 = 1'b1;
  endtask

  logic [15:0] f;

  initial begin
    clr = 1'b0; ser0 = 1'b1; ser1 = 1'b1; ready = 1'b1;

    // 1: reset with a toggling line
    ser0 = 1'b0; tick();
    ser0 = 1'b1; tick();
    chk("rst_valid", valid0, 0);
    chk("rst_data", data0, 0);
    chk("rst_perr", perr0, 0);
    chk("rst_ferr", ferr0, 0);
    chk("rst_ovr", ovr0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_busy1", busy1, 0);
    clr = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy0, 0);
    chk("idle_valid", valid0, 0);

    // 2: good frame, latency FRAME_LEN edges
    f = mk(8'hA5, 1'b0, 1'b1, 1);
    send(f, 0, FRAME_LEN - 1, 0);
    chk("a5_early", valid0, 0);
    chk("a5_busy", busy0, 1);
    send(f, FRAME_LEN - 1, FRAME_LEN, 0);
    chk("a5_valid", valid0, 1);
    chk("a5_data", data0, 32'hA5);
    chk("a5_perr", perr0, 0);
    chk("a5_ferr", ferr0, 0);
    tick();
    chk("a5_onecyc", valid0, 0);
    chk("a5_keep", data0, 32'hA5);

    // 3: parity error
    send(mk(8'h01, 1'b0, 1'b1, 1), 0, 11, 0);
    chk("p_data", data0, 32'h01);
    chk("p_perr", perr0, 1);
    chk("p_ferr", ferr0, 0);
    tick();

    // 4: framing error, low hold, then clean frame
    f = mk(8'h3C, 1'b0, 1'b0, 1);
    send(f, 0, 10, 0);
    ser0 = 1'b0; tick();
    chk("f_ferr", ferr0, 1);
    chk("f_data", data0, 32'h3C);
    chk("f_perr", perr0, 0);
    repeat (3) tick();
    chk("f_hold_valid", valid0, 0);
    chk("f_hold_busy", busy0, 1);
    ser0 = 1'b1; tick();
    chk("f_idle", busy0, 0);
    send(mk(8'h5A, 1'b0, 1'b1, 1), 0, 11, 0);
    chk("f2_valid", valid0, 1);
    chk("f2_data", data0, 32'h5A);
    chk("f2_ferr", ferr0, 0);
    chk("f2_perr", perr0, 0);
    tick();

    // 5: overrun with zero-gap frames
    ready = 1'b0;
    send(mk(8'h3C, 1'b0, 1'b1, 1), 0, 11, 0);
    chk("o1_valid", valid0, 1);
    chk("o1_ovr", ovr0, 0);
    send(mk(8'hC3, 1'b0, 1'b1, 1), 0, 11, 0);
    chk("o2_data", data0, 32'h3C);
    chk("o2_valid", valid0, 1);
    chk("o2_ovr", ovr0, 1);
    ready = 1'b1; tick();
    chk("o3_valid", valid0, 0);
    chk("o3_ovr", ovr0, 1);
    chk("o3_data", data0, 32'h3C);

    // 6: reset mid-frame, then clean frame with latency
    send(mk(8'hFF, 1'b0, 1'b1, 1), 0, 5, 0);
    chk("m_busy", busy0, 1);
    clr = 1'b0; tick();
    clr = 1'b1;
    chk("m_idle", busy0, 0);
    chk("m_valid", valid0, 0);
    chk("m_ovr", ovr0, 0);
    f = mk(8'h5A, 1'b0, 1'b1, 1);
    send(f, 0, 10, 0);
    chk("m_early", valid0, 0);
    send(f, 10, 11, 0);
    chk("m_valid2", valid0, 1);
    chk("m_data", data0, 32'h5A);

    // 6b: no-parity build, 10-edge frame
    f = mk(8'h5A, 1'b0, 1'b1, 0);
    send(f, 0, 9, 1);
    chk("np_early", valid1, 0);
    send(f, 9, 10, 1);
    chk("np_valid", valid1, 1);
    chk("np_data", data1, 32'h5A);
    chk("np_perr", perr1, 0);
    chk("np_ferr", ferr1, 0);
    chk("np_quiet0", busy0, 0);
    tick();
    chk("np_drain", valid1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
